exec_button_debouncer: RTL and testbench



---
 rtl/exec_button_debouncer_pkg.sv | 14 +
 rtl/exec_button_debouncer_sync_2ff.sv | 27 ++
 rtl/exec_button_debouncer.sv | 103 ++++++++++
 tb/tb_exec_button_debouncer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exec_button_debouncer_pkg.sv
// Shared state encodings and board defaults for the EXEC button debouncer.
package exec_button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // 5 ms at the 50 MHz board clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage

// File: rtl/exec_button_debouncer_sync_2ff.sv
// Two-flop synchroniser with async active-high reset to a chosen level.
// Latency 2 edges; no backpressure (plain level path).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/exec_button_debouncer.sv
// Debounces the EXEC pushbutton into a clean level, press/release strobes and a press count.
// Latency DEBOUNCE_CYCLES+3 edges from a stable change; no backpressure, strobes are one cycle.
module exec_button_debouncer
  import exec_button_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = 24,
  parameter bit          BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       BTN_RAW,
  output logic       EXEC,
  output logic       EXEC_PULSE,
  output logic       RELEASE_PULSE,
  output logic [7:0] PRESS_COUNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 btn;
  logic                 s;
  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 exec_q;
  logic                 exec_pulse_q;
  logic                 release_pulse_q;
  logic [7:0]           press_cnt_q;
  logic                 cnt_done;

  assign btn = BTN_RAW ^ BTN_ACTIVE_LOW;

  sync_2ff #(
    .RESET_VAL(1'b0)
  ) u_sync (
    .clk_i(CLOCK),
    .rst_i(RESET),
    .d_i  (btn),
    .q_o  (s)
  );

  assign cnt_done = (cnt_q == CNT_LAST);

  // Any return to the old level drops back to the settled state, so a later
  // change restarts qualification from zero.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      exec_q          <= 1'b0;
      exec_pulse_q    <= 1'b0;
      release_pulse_q <= 1'b0;
      press_cnt_q     <= 8'd0;
    end else begin
      exec_pulse_q    <= 1'b0;
      release_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_q <= IDLE;
          end else if (cnt_done) begin
            state_q      <= HELD;
            exec_q       <= 1'b1;
            exec_pulse_q <= 1'b1;
            press_cnt_q  <= press_cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_q <= HELD;
          end else if (cnt_done) begin
            state_q         <= IDLE;
            exec_q          <= 1'b0;
            release_pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign EXEC          = exec_q;
  assign EXEC_PULSE    = exec_pulse_q;
  assign RELEASE_PULSE = release_pulse_q;
  assign PRESS_COUNT   = press_cnt_q;

endmodule

// File: tb/tb_exec_button_debouncer.sv
// Bench for exec_button_debouncer: run-length reference model checked every cycle plus directed literal checks.
module tb_exec_button_debouncer;

  localparam int DEB = 4;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       btn0  = 1'b0;
  logic       btn1  = 1'b1;
  logic       exec0, epulse0, rpulse0;
  logic       exec1, epulse1, rpulse1;
  logic [7:0] pcnt0, pcnt1;

  int passed = 0;
  int total  = 0;

  always #5 CLOCK = ~CLOCK;

  exec_button_debouncer #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(24), .BTN_ACTIVE_LOW(1'b0)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .BTN_RAW(btn0),
    .EXEC(exec0), .EXEC_PULSE(epulse0), .RELEASE_PULSE(rpulse0), .PRESS_COUNT(pcnt0)
  );

  exec_button_debouncer #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(24), .BTN_ACTIVE_LOW(1'b1)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .BTN_RAW(btn1),
    .EXEC(exec1), .EXEC_PULSE(epulse1), .RELEASE_PULSE(rpulse1), .PRESS_COUNT(pcnt1)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: the output level flips once the synchronised input has
  // differed from it on DEB+1 consecutive edges (one edge to notice, DEB to count).
  logic       m_sy0 [2];
  logic       m_sy1 [2];
  logic       m_exec[2];
  int         m_run [2];
  logic [7:0] m_cnt [2];
  logic       m_press[2];
  logic       m_rel [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_sy0[i] = 0; m_sy1[i] = 0; m_exec[i] = 0; m_run[i] = 0;
      m_cnt[i] = 0; m_press[i] = 0; m_rel[i] = 0;
    end
  end

  task automatic model_step();
    logic s;
    for (int i = 0; i < 2; i++) begin
      if (RESET) begin
        m_sy0[i] = 0; m_sy1[i] = 0; m_exec[i] = 0; m_run[i] = 0;
        m_cnt[i] = 0; m_press[i] = 0; m_rel[i] = 0;
      end else begin
        s = m_sy1[i];
        m_press[i] = 0;
        m_rel[i]   = 0;
        if (s != m_exec[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_exec[i] = s;
            m_run[i]  = 0;
            if (s) begin
              m_press[i] = 1;
              m_cnt[i]   = m_cnt[i] + 8'd1;
            end else begin
              m_rel[i] = 1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
        m_sy1[i] = m_sy0[i];
        m_sy0[i] = (i == 0) ? btn0 : ~btn1;
      end
    end
  endtask

  always @(posedge CLOCK) begin
    model_step();
    #2;
    check("exec0",   exec0,   m_exec[0]);
    check("epulse0", epulse0, m_press[0]);
    check("rpulse0", rpulse0, m_rel[0]);
    check("pcnt0",   pcnt0,   m_cnt[0]);
    check("exec1",   exec1,   m_exec[1]);
    check("epulse1", epulse1, m_press[1]);
    check("rpulse1", rpulse1, m_rel[1]);
    check("pcnt1",   pcnt1,   m_cnt[1]);
    check("strobe_excl0", int'(epulse0 & rpulse0), 0);
  end

  // Counts rising edges until the watched output reaches lvl, bounded at 40.
  task automatic wait_out(input int sel, input logic lvl, output int n);
    logic v;
    n = 0;
    do begin
      @(posedge CLOCK);
      #1;
      n++;
      case (sel)
        0:       v = exec0;
        1:       v = epulse0;
        default: v = exec1;
      endcase
    end while (v != lvl && n < 40);
  endtask

  task automatic press_release0();
    @(negedge CLOCK); btn0 = 1'b1;
    repeat (9) @(negedge CLOCK);
    btn0 = 1'b0;
    repeat (9) @(negedge CLOCK);
  endtask

  initial begin
    int n;
    int len;

    // Reset then idle
    @(negedge CLOCK); RESET = 1'b1;
    #1;
    check("rst_exec", exec0, 0);
    check("rst_pcnt", pcnt0, 0);
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("idle_exec", exec0, 0);
    check("idle_pcnt", pcnt0, 0);

    // Clean press
    btn0 = 1'b1;
    wait_out(0, 1'b1, n);
    check("press_latency", n, 7);
    check("press_pulse", epulse0, 1);
    check("press_pcnt", pcnt0, 1);

    // Release bounce while held
    repeat (5) @(negedge CLOCK);
    btn0 = 1'b0;
    repeat (2) @(negedge CLOCK);
    btn0 = 1'b1;
    repeat (12) @(negedge CLOCK);
    check("relbounce_exec", exec0, 1);
    check("relbounce_pcnt", pcnt0, 1);

    // Clean release
    btn0 = 1'b0;
    wait_out(0, 1'b0, n);
    check("release_latency", n, 7);
    check("release_pulse", rpulse0, 1);

    // Press bounce rejection
    @(negedge CLOCK);
    btn0 = 1'b1; repeat (3) @(negedge CLOCK);
    btn0 = 1'b0; repeat (2) @(negedge CLOCK);
    btn0 = 1'b1; repeat (3) @(negedge CLOCK);
    btn0 = 1'b0; repeat (12) @(negedge CLOCK);
    check("bounce_exec", exec0, 0);
    check("bounce_pcnt", pcnt0, 1);

    // Reset mid-press with the button still held
    btn0 = 1'b1;
    repeat (4) @(negedge CLOCK);
    RESET = 1'b1;
    #1;
    check("midrst_exec", exec0, 0);
    check("midrst_pcnt", pcnt0, 0);
    @(negedge CLOCK); @(negedge CLOCK);
    RESET = 1'b0;
    wait_out(1, 1'b1, n);
    check("midrst_pulse_latency", n, 7);
    check("midrst_pcnt_after", pcnt0, 1);
    @(negedge CLOCK); btn0 = 1'b0;
    repeat (10) @(negedge CLOCK);

    // Active-low instance: 1 -> 0 step is a press
    btn1 = 1'b0;
    wait_out(2, 1'b1, n);
    check("actlow_latency", n, 7);
    check("actlow_pcnt", pcnt1, 1);
    @(negedge CLOCK); btn1 = 1'b1;
    repeat (10) @(negedge CLOCK);

    // Randomised bouncy levels on both buttons
    for (int k = 0; k < 120; k++) begin
      len = $urandom_range(1, 9);
      btn0 = ~btn0;
      if ($urandom_range(0, 1) == 1) btn1 = ~btn1;
      repeat (len) @(negedge CLOCK);
    end
    btn0 = 1'b0; btn1 = 1'b1;
    repeat (10) @(negedge CLOCK);

    // Wrap: 256 presses from reset
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    for (int k = 0; k < 255; k++) press_release0();
    check("pcnt_255", pcnt0, 255);
    press_release0();
    check("pcnt_wrap", pcnt0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
